// File: rtl/forwarding_unit_gen_pkg.sv
// Shared definitions for the EXE-stage forwarding unit: select encoding,
// the shadow-pipeline entry layout and the select-width derivation.
package forwarding_unit_gen_pkg;

    // Select value meaning "take the operand from the register file".
    localparam int FWD_SEL_RF = 0;

    // Widest register address the shadow entries can hold. Narrower address
    // buses are zero-extended on entry, which keeps equality compares exact.
    localparam int FWD_MAX_ADDR_W = 8;

    // One in-flight writer as tracked by the shadow pipeline.
    typedef struct packed {
        logic                      valid;
        logic                      wb_en;
        logic                      is_load;
        logic [FWD_MAX_ADDR_W-1:0] dest;
    } shadow_entry_t;

    // Bits needed to encode "register file" plus stages 1..depth-1.
    function automatic int fwd_sel_w(input int depth);
        if (depth <= 2) begin
            return 1;
        end
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/forwarding_unit_gen_match_prio.sv
// Per-operand priority matcher: compares one ID source address against the
// forwarding candidates (EXE..stage DEPTH-2) and reports the youngest live
// writer, plus whether any matching writer is a load that is not ready yet.
module fwd_match_prio
    import forwarding_unit_gen_pkg::*;
#(
    parameter int DEPTH      = 3,
    parameter int LOAD_RDY   = 2,
    parameter int ZERO_NOFWD = 0,
    parameter int SEL_W      = 2
) (
    input  shadow_entry_t [DEPTH-2:0] cand_i,
    input  logic [FWD_MAX_ADDR_W-1:0] src_i,
    input  logic                      used_i,
    output logic                      hit_o,
    output logic [SEL_W-1:0]          idx_o,
    output logic                      load_haz_o
);

    logic [DEPTH-2:0] candLive;

    // A candidate is live when it will really write a register; register 0
    // is optionally treated as a hard-wired zero that never forwards.
    always_comb begin
        candLive = '0;
        for (int j = 0; j < DEPTH - 1; j++) begin
            candLive[j] = cand_i[j].valid & cand_i[j].wb_en &
                          ~((ZERO_NOFWD != 0) && (cand_i[j].dest == '0));
        end
    end

    // Scan oldest to youngest so the youngest matching writer wins the index;
    // the load hazard flag collects every matching not-yet-ready load.
    always_comb begin
        hit_o      = 1'b0;
        idx_o      = '0;
        load_haz_o = 1'b0;
        for (int j = DEPTH - 2; j >= 0; j--) begin
            if (used_i && candLive[j] && (cand_i[j].dest == src_i)) begin
                hit_o = 1'b1;
                idx_o = SEL_W'(j);
                if (cand_i[j].is_load && (j + 1 < LOAD_RDY)) begin
                    load_haz_o = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/forwarding_unit_gen.sv
// Parametrised EXE-stage forwarding unit. Tracks in-flight writers in a
// shadow pipeline, produces a registered forwarding select per EXE operand,
// raises a load-use stall toward IF/ID and counts stall cycles.
// The final (WB) stage is not stored: its writer is never a forwarding
// candidate because the register file is write-through, so only the
// DEPTH-1 compare stages need registers.
module forwarding_unit_gen
    import forwarding_unit_gen_pkg::*;
#(
    parameter int REG_ADDR_W = 4,
    parameter int NUM_SRC    = 3,
    parameter int DEPTH      = 3,
    parameter int SEL_W      = fwd_sel_w(DEPTH),
    parameter int LOAD_RDY   = 2,
    parameter int ZERO_NOFWD = 0,
    parameter int CNT_W      = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          pipe_en,
    input  logic                          flush,
    input  logic                          fwd_en,
    input  logic                          id_valid,
    input  logic                          id_wb_en,
    input  logic                          id_is_load,
    input  logic [REG_ADDR_W-1:0]         id_dest,
    input  logic [NUM_SRC*REG_ADDR_W-1:0] id_src,
    input  logic [NUM_SRC-1:0]            id_src_used,
    output logic                          hazard_stall,
    output logic [NUM_SRC*SEL_W-1:0]      exe_sel,
    output logic [CNT_W-1:0]              stall_cnt
);

    localparam int NCAND = DEPTH - 1;

    shadow_entry_t [NCAND-1:0] shadow_q;
    shadow_entry_t [NCAND-1:0] shadow_d;
    logic [NUM_SRC*SEL_W-1:0]  exe_sel_q;
    logic [NUM_SRC*SEL_W-1:0]  exe_sel_d;
    logic [CNT_W-1:0]          stall_cnt_q;
    logic [CNT_W-1:0]          stall_cnt_d;

    logic [NUM_SRC-1:0]        opHit;
    logic [NUM_SRC-1:0]        opLoadHaz;
    logic [NUM_SRC-1:0]        opStall;
    logic [NUM_SRC*SEL_W-1:0]  opIdx;
    logic                      idAccept;

    genvar g;
    generate
        for (g = 0; g < NUM_SRC; g++) begin : gen_op
            logic [FWD_MAX_ADDR_W-1:0] srcAddr;
            assign srcAddr = FWD_MAX_ADDR_W'(id_src[g*REG_ADDR_W +: REG_ADDR_W]);

            fwd_match_prio #(
                .DEPTH      (DEPTH),
                .LOAD_RDY   (LOAD_RDY),
                .ZERO_NOFWD (ZERO_NOFWD),
                .SEL_W      (SEL_W)
            ) u_match (
                .cand_i     (shadow_q),
                .src_i      (srcAddr),
                .used_i     (id_src_used[g]),
                .hit_o      (opHit[g]),
                .idx_o      (opIdx[g*SEL_W +: SEL_W]),
                .load_haz_o (opLoadHaz[g])
            );
        end
    endgenerate

    // Stall when an operand depends on a writer whose data cannot be
    // bypassed yet; a flushed or empty ID slot never stalls.
    always_comb begin
        opStall      = fwd_en ? opLoadHaz : opHit;
        hazard_stall = id_valid & ~flush & (|opStall);
        idAccept     = id_valid & ~flush & ~hazard_stall;
    end

    // Advance the shadow pipeline; a rejected ID instruction becomes a bubble.
    always_comb begin
        shadow_d = shadow_q;
        for (int k = NCAND - 1; k >= 1; k--) begin
            shadow_d[k] = shadow_q[k-1];
        end
        shadow_d[0] = '0;
        if (idAccept) begin
            shadow_d[0].valid   = 1'b1;
            shadow_d[0].wb_en   = id_wb_en;
            shadow_d[0].is_load = id_is_load;
            shadow_d[0].dest    = FWD_MAX_ADDR_W'(id_dest);
        end
    end

    // Writer at compare stage j sits one stage further on once ID enters EXE.
    always_comb begin
        for (int i = 0; i < NUM_SRC; i++) begin
            exe_sel_d[i*SEL_W +: SEL_W] = SEL_W'(FWD_SEL_RF);
            if (idAccept && fwd_en && opHit[i]) begin
                exe_sel_d[i*SEL_W +: SEL_W] = opIdx[i*SEL_W +: SEL_W] + SEL_W'(1);
            end
        end
    end

    // Saturating count of cycles in which the pipeline really stalled.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (hazard_stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    // State update: reset beats freeze, freeze holds everything.
    always_ff @(posedge clk) begin
        if (!rst) begin
            shadow_q    <= '0;
            exe_sel_q   <= '0;
            stall_cnt_q <= '0;
        end else if (pipe_en) begin
            shadow_q    <= shadow_d;
            exe_sel_q   <= exe_sel_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign exe_sel   = exe_sel_q;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_forwarding_unit_gen.sv
// Directed self-checking bench for forwarding_unit_gen. A second instance
// with the zero register excluded and a 2-bit stall counter covers the
// zero-register and saturation behaviour.
module tb_forwarding_unit_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        pipe_en;
    logic        flush;
    logic        fwd_en;
    logic        id_valid;
    logic        id_wb_en;
    logic        id_is_load;
    logic [3:0]  id_dest;
    logic [11:0] id_src;
    logic [2:0]  id_src_used;

    logic        hazard_stall;
    logic [5:0]  exe_sel;
    logic [15:0] stall_cnt;
    logic        hazZ;
    logic [5:0]  selZ;
    logic [1:0]  cntZ;

    int errors = 0;
    int checks = 0;

    forwarding_unit_gen dut (
        .clk          (clk),
        .rst          (rst),
        .pipe_en      (pipe_en),
        .flush        (flush),
        .fwd_en       (fwd_en),
        .id_valid     (id_valid),
        .id_wb_en     (id_wb_en),
        .id_is_load   (id_is_load),
        .id_dest      (id_dest),
        .id_src       (id_src),
        .id_src_used  (id_src_used),
        .hazard_stall (hazard_stall),
        .exe_sel      (exe_sel),
        .stall_cnt    (stall_cnt)
    );

    forwarding_unit_gen #(.ZERO_NOFWD(1), .CNT_W(2)) dutZ (
        .clk          (clk),
        .rst          (rst),
        .pipe_en      (pipe_en),
        .flush        (flush),
        .fwd_en       (fwd_en),
        .id_valid     (id_valid),
        .id_wb_en     (id_wb_en),
        .id_is_load   (id_is_load),
        .id_dest      (id_dest),
        .id_src       (id_src),
        .id_src_used  (id_src_used),
        .hazard_stall (hazZ),
        .exe_sel      (selZ),
        .stall_cnt    (cntZ)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setId(input logic v, input logic wb, input logic ld, input logic [3:0] dest,
                         input logic [3:0] s0, input logic [3:0] s1, input logic [3:0] s2,
                         input logic [2:0] used);
        id_valid    = v;
        id_wb_en    = wb;
        id_is_load  = ld;
        id_dest     = dest;
        id_src      = {s2, s1, s0};
        id_src_used = used;
        #1;
    endtask

    task automatic drain();
        setId(0, 0, 0, 0, 0, 0, 0, 3'b000);
        repeat (3) tick();
    endtask

    task automatic test_reset();
        rst = 1'b0; pipe_en = 1'b1; flush = 1'b0; fwd_en = 1'b1;
        setId(0, 0, 0, 0, 0, 0, 0, 3'b000);
        tick(); tick();
        rst = 1'b1;
        #1;
        checks++;
        if (exe_sel !== 6'h00) begin errors++; $display("[TB] FAIL reset_sel: got %h expected %h", exe_sel, 6'h00); end
        checks++;
        if (stall_cnt !== 16'd0) begin errors++; $display("[TB] FAIL reset_cnt: got %0d expected 0", stall_cnt); end
        setId(1, 1, 0, 4, 3, 3, 3, 3'b111);
        checks++;
        if (hazard_stall !== 1'b0) begin errors++; $display("[TB] FAIL reset_haz: got %b expected 0", hazard_stall); end
    endtask

    task automatic test_back_to_back();
        drain();
        setId(1, 1, 0, 3, 0, 0, 0, 3'b000);
        tick();
        setId(1, 1, 0, 8, 3, 0, 0, 3'b001);
        checks++;
        if (hazard_stall !== 1'b0) begin errors++; $display("[TB] FAIL b2b_haz: got %b expected 0", hazard_stall); end
        tick();
        checks++;
        if (exe_sel !== 6'h01) begin errors++; $display("[TB] FAIL b2b_sel_mem: got %h expected %h", exe_sel, 6'h01); end
        setId(1, 1, 0, 9, 0, 0, 0, 3'b000);
        tick();
        checks++;
        if (exe_sel !== 6'h00) begin errors++; $display("[TB] FAIL b2b_sel_none: got %h expected %h", exe_sel, 6'h00); end
        setId(1, 1, 0, 10, 0, 0, 0, 3'b000);
        tick();
        setId(1, 0, 0, 0, 9, 0, 0, 3'b001);
        checks++;
        if (hazard_stall !== 1'b0) begin errors++; $display("[TB] FAIL b2b_gap_haz: got %b expected 0", hazard_stall); end
        tick();
        checks++;
        if (exe_sel !== 6'h02) begin errors++; $display("[TB] FAIL b2b_sel_wb: got %h expected %h", exe_sel, 6'h02); end
    endtask

    task automatic test_load_use();
        drain();
        setId(1, 1, 1, 5, 0, 0, 0, 3'b000);
        tick();
        setId(1, 1, 0, 11, 0, 5, 0, 3'b010);
        checks++;
        if (hazard_stall !== 1'b1) begin errors++; $display("[TB] FAIL lu_haz_on: got %b expected 1", hazard_stall); end
        tick();
        checks++;
        if (hazard_stall !== 1'b0) begin errors++; $display("[TB] FAIL lu_haz_off: got %b expected 0", hazard_stall); end
        checks++;
        if (exe_sel !== 6'h00) begin errors++; $display("[TB] FAIL lu_bubble_sel: got %h expected %h", exe_sel, 6'h00); end
        checks++;
        if (stall_cnt !== 16'd1) begin errors++; $display("[TB] FAIL lu_cnt: got %0d expected 1", stall_cnt); end
        tick();
        checks++;
        if (exe_sel !== 6'h08) begin errors++; $display("[TB] FAIL lu_sel_wb: got %h expected %h", exe_sel, 6'h08); end
        checks++;
        if (stall_cnt !== 16'd1) begin errors++; $display("[TB] FAIL lu_cnt_hold: got %0d expected 1", stall_cnt); end
    endtask

    task automatic test_priority();
        drain();
        setId(1, 1, 0, 7, 0, 0, 0, 3'b000);
        tick();
        setId(1, 1, 0, 7, 0, 0, 0, 3'b000);
        tick();
        setId(1, 0, 0, 0, 7, 7, 7, 3'b101);
        checks++;
        if (hazard_stall !== 1'b0) begin errors++; $display("[TB] FAIL prio_haz: got %b expected 0", hazard_stall); end
        tick();
        checks++;
        if (exe_sel !== 6'h11) begin errors++; $display("[TB] FAIL prio_sel: got %h expected %h", exe_sel, 6'h11); end
    endtask

    task automatic test_stall_only();
        drain();
        fwd_en = 1'b0;
        setId(1, 1, 0, 2, 0, 0, 0, 3'b000);
        tick();
        setId(1, 0, 0, 0, 2, 0, 0, 3'b001);
        checks++;
        if (hazard_stall !== 1'b1) begin errors++; $display("[TB] FAIL so_haz_exe: got %b expected 1", hazard_stall); end
        tick();
        checks++;
        if (hazard_stall !== 1'b1) begin errors++; $display("[TB] FAIL so_haz_mem: got %b expected 1", hazard_stall); end
        checks++;
        if (exe_sel !== 6'h00) begin errors++; $display("[TB] FAIL so_sel_a: got %h expected %h", exe_sel, 6'h00); end
        tick();
        checks++;
        if (hazard_stall !== 1'b0) begin errors++; $display("[TB] FAIL so_haz_wb: got %b expected 0", hazard_stall); end
        checks++;
        if (exe_sel !== 6'h00) begin errors++; $display("[TB] FAIL so_sel_b: got %h expected %h", exe_sel, 6'h00); end
        tick();
        checks++;
        if (exe_sel !== 6'h00) begin errors++; $display("[TB] FAIL so_sel_c: got %h expected %h", exe_sel, 6'h00); end
        checks++;
        if (stall_cnt !== 16'd3) begin errors++; $display("[TB] FAIL so_cnt: got %0d expected 3", stall_cnt); end
        fwd_en = 1'b1;
    endtask

    task automatic test_freeze_flush();
        drain();
        setId(1, 1, 0, 6, 0, 0, 0, 3'b000);
        tick();
        setId(1, 1, 1, 5, 6, 0, 0, 3'b001);
        tick();
        checks++;
        if (exe_sel !== 6'h01) begin errors++; $display("[TB] FAIL ff_pre_sel: got %h expected %h", exe_sel, 6'h01); end
        pipe_en = 1'b0;
        setId(1, 1, 0, 11, 0, 5, 0, 3'b010);
        for (int n = 0; n < 3; n++) begin
            tick();
            checks++;
            if (hazard_stall !== 1'b1) begin errors++; $display("[TB] FAIL ff_haz_%0d: got %b expected 1", n, hazard_stall); end
            checks++;
            if (exe_sel !== 6'h01) begin errors++; $display("[TB] FAIL ff_sel_%0d: got %h expected %h", n, exe_sel, 6'h01); end
            checks++;
            if (stall_cnt !== 16'd3) begin errors++; $display("[TB] FAIL ff_cnt_%0d: got %0d expected 3", n, stall_cnt); end
        end
        pipe_en = 1'b1;
        flush   = 1'b1;
        #1;
        checks++;
        if (hazard_stall !== 1'b0) begin errors++; $display("[TB] FAIL fl_haz: got %b expected 0", hazard_stall); end
        tick();
        flush = 1'b0;
        setId(1, 0, 0, 0, 11, 0, 0, 3'b001);
        tick();
        checks++;
        if (exe_sel !== 6'h00) begin errors++; $display("[TB] FAIL fl_bubble: got %h expected %h", exe_sel, 6'h00); end
        checks++;
        if (stall_cnt !== 16'd3) begin errors++; $display("[TB] FAIL fl_cnt: got %0d expected 3", stall_cnt); end
    endtask

    task automatic test_reset_mid();
        drain();
        setId(1, 1, 0, 6, 0, 0, 0, 3'b000);
        tick();
        setId(1, 1, 1, 5, 6, 0, 0, 3'b001);
        tick();
        setId(1, 1, 0, 11, 0, 5, 0, 3'b010);
        checks++;
        if (hazard_stall !== 1'b1) begin errors++; $display("[TB] FAIL rm_pre_haz: got %b expected 1", hazard_stall); end
        rst     = 1'b0;
        pipe_en = 1'b0;
        tick();
        checks++;
        if (exe_sel !== 6'h00) begin errors++; $display("[TB] FAIL rm_sel: got %h expected %h", exe_sel, 6'h00); end
        checks++;
        if (stall_cnt !== 16'd0) begin errors++; $display("[TB] FAIL rm_cnt: got %0d expected 0", stall_cnt); end
        checks++;
        if (hazard_stall !== 1'b0) begin errors++; $display("[TB] FAIL rm_haz: got %b expected 0", hazard_stall); end
        checks++;
        if (cntZ !== 2'd0) begin errors++; $display("[TB] FAIL rm_cntz: got %0d expected 0", cntZ); end
        rst     = 1'b1;
        pipe_en = 1'b1;
    endtask

    task automatic test_zero_reg();
        drain();
        setId(1, 1, 0, 0, 0, 0, 0, 3'b000);
        tick();
        setId(1, 1, 0, 12, 0, 0, 0, 3'b001);
        checks++;
        if (hazZ !== 1'b0) begin errors++; $display("[TB] FAIL zr_hazz: got %b expected 0", hazZ); end
        tick();
        checks++;
        if (exe_sel !== 6'h01) begin errors++; $display("[TB] FAIL zr_sel_fwd: got %h expected %h", exe_sel, 6'h01); end
        checks++;
        if (selZ !== 6'h00) begin errors++; $display("[TB] FAIL zr_selz: got %h expected %h", selZ, 6'h00); end
        setId(1, 1, 1, 0, 0, 0, 0, 3'b000);
        tick();
        setId(1, 0, 0, 0, 0, 0, 0, 3'b001);
        checks++;
        if (hazard_stall !== 1'b1) begin errors++; $display("[TB] FAIL zr_haz_load: got %b expected 1", hazard_stall); end
        checks++;
        if (hazZ !== 1'b0) begin errors++; $display("[TB] FAIL zr_hazz_load: got %b expected 0", hazZ); end
        setId(0, 0, 0, 0, 0, 0, 0, 3'b000);
    endtask

    task automatic test_saturate();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        fwd_en = 1'b0;
        for (int n = 0; n < 2; n++) begin
            setId(1, 1, 0, 2, 0, 0, 0, 3'b000);
            tick();
            setId(1, 0, 0, 0, 2, 0, 0, 3'b001);
            repeat (3) tick();
        end
        checks++;
        if (stall_cnt !== 16'd4) begin errors++; $display("[TB] FAIL sat_cnt: got %0d expected 4", stall_cnt); end
        checks++;
        if (cntZ !== 2'd3) begin errors++; $display("[TB] FAIL sat_cntz: got %0d expected 3", cntZ); end
        fwd_en = 1'b1;
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_load_use();
        test_priority();
        test_stall_only();
        test_freeze_flush();
        test_reset_mid();
        test_zero_reg();
        test_saturate();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/forwarding_unit_gen.md
Name: forwarding_unit_gen

Overview:
- Parametrised successor to the EXE-stage forwarding logic, for N operands and a configurable pipeline depth.
- Keeps its own shadow copy of in-flight writers, EXE..WB, as a register pipeline.
- For each EXE operand it produces a registered forwarding select. It also raises a load-use stall toward IF/ID.
- Runs in forwarding mode or stall-only mode, and counts stall cycles.
- Sits between the ID/EXE pipeline register and the EXE operand muxes.

Parameters:
- REG_ADDR_W, 4: register address width (same as REG_FILE_ADDR_LEN).
- NUM_SRC, 3: operands tracked per instruction (val1, val2, store value).
- DEPTH, 3: shadow stages; index 0=EXE, 1=MEM, ..., DEPTH-1=WB. Minimum 2.
- SEL_W, $clog2(DEPTH): select width per operand. Default 2, same as FORW_SEL_LEN.
- LOAD_RDY, 2: lowest stage index whose load data can be forwarded (2=WB).
- ZERO_NOFWD, 0: when 1, register address 0 never matches.
- CNT_W, 16: stall counter width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset.
- pipe_en  in  1  pipeline advance; 0 freezes the whole block.
- flush  in  1  branch flush of the ID instruction.
- fwd_en  in  1  1=forwarding mode, 0=stall-only mode.
- id_valid  in  1  ID holds a real instruction.
- id_wb_en  in  1  ID instruction writes the register file.
- id_is_load  in  1  ID instruction is a load.
- id_dest  in  REG_ADDR_W  ID destination register.
- id_src  in  NUM_SRC*REG_ADDR_W  ID source addresses; operand i is at bits [i*REG_ADDR_W +: REG_ADDR_W].
- id_src_used  in  NUM_SRC  per-operand "source is read" mask.
- hazard_stall  out  1  combinational; hold IF/ID and insert a bubble.
- exe_sel  out  NUM_SRC*SEL_W  registered select per EXE operand. 0=register file, k=forward from stage k.
- stall_cnt  out  CNT_W  saturating count of stall cycles.

Behaviour:
- Reset: one clock; synchronous, active-low reset on rst, sampled at posedge clk. Reset has priority over pipe_en.
- Reset values: all shadow entries invalid, exe_sel=0, stall_cnt=0.
- hazard_stall tracks the cleared state, so it reads 0 in the cycle after reset.
- Shadow entry fields: {valid, wb_en, is_load, dest}.
- Writer at stage j is "live" when valid & wb_en, and not (ZERO_NOFWD & dest==0).
- Match(i,j): id_src_used[i], and operand i address == dest of live entry j, for j in 0..DEPTH-2.
- hazard_stall = id_valid & ~flush & any Match(i,j) meeting either condition:
  - fwd_en=1: entry j is a load and j+1 < LOAD_RDY;
  - fwd_en=0: any j.
- Each pipe_en=1 edge:
  - entry k <= entry k-1 for k≥1.
  - entry 0 <= ID fields if id_valid & ~flush & ~hazard_stall; otherwise entry 0 becomes a bubble (valid=0).
  - exe_sel[i] <= j+1 for the lowest j with Match(i,j). Youngest writer wins.
  - exe_sel[i] <= 0 if no match, fwd_en=0, or the ID instruction is not loaded into entry 0.
- pipe_en=0: all entries, exe_sel and stall_cnt hold. hazard_stall is still evaluated on the held state.
- Entry DEPTH-1 is never a forwarding candidate for ID. The register file is write-through, so a retiring writer needs no bypass.
- Simultaneous flush and hazard: flush wins. hazard_stall=0, and a bubble enters.
- stall_cnt increments on pipe_en & hazard_stall and saturates at all-ones.
- Reset mid-stall clears everything. The stalled ID instruction is re-presented by upstream logic.
- No arithmetic on addresses; comparisons are equality only. Match indices are bounded by DEPTH-2, so SEL_W always holds j+1.

Decomposition:
- Shared package/defines:
  - FWD_SEL_RF = 0;
  - shadow-entry struct (valid, wb_en, is_load, dest);
  - SEL_W derivation.
- One sub-module, fwd_match_prio: per-operand priority matcher over DEPTH-1 entries. It returns hit, index and load-hazard flag, and is instantiated NUM_SRC times.

Test Plan:
- Back-to-back ALU, defaults, fwd_en=1:
  - issue "R3<-…", then ID src0=3;
  - next edge gives exe_sel[0]=1 (MEM) and hazard_stall=0;
  - with one independent instruction in between, exe_sel[0]=2.
- Load-use:
  - load to R5 in entry 0, ID src1=5 -> hazard_stall=1 for exactly one cycle and a bubble enters EXE;
  - after the next edge, hazard_stall=0 and the following edge gives exe_sel[1]=2; stall_cnt=1.
- Priority: R7 written by both the MEM and EXE entries, ID src2=7 -> exe_sel[2]=1 (youngest).
- Stall-only mode, fwd_en=0:
  - ALU write to R2, then reader of R2 -> stall while the writer sits in entries 0..DEPTH-2 (2 cycles);
  - exe_sel stays 0 throughout.
- Freeze and flush:
  - pipe_en=0 for 3 cycles during a load-use stall -> entries, exe_sel and stall_cnt hold;
  - flush=1 with hazard pending -> hazard_stall=0 and a bubble enters.
- Reset and zero register:
  - rst=0 mid-sequence -> all outputs 0 on the next edge;
  - ZERO_NOFWD=1 with writer R0 and reader R0 -> exe_sel=0 and no stall.
